fuzzy_defuzz: RTL and testbench
===============================

# fuzzy_defuzz

Sequential weighted-average (singleton centroid) defuzzifier that sits directly downstream of the trapezoid membership stage and the rule-strength logic. It consumes a stream of rule firing strengths μ (Q1.15) and their paired singleton consequents z (Q7.0). On the last beat it computes y = Σ(μ·z) / Σμ with a serial divider and returns a crisp Q7.0 output over a valid/ready handshake.

## Interface
- `N_RULES`, default 9: maximum rule beats per frame; sizes the accumulators.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: rule beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_mu` in 16: rule strength, Q1.15 unsigned.
- `in_z` in 8: singleton consequent, signed Q7.0.
- `in_last` in 1: final beat of the frame.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_y` out 8: crisp output, signed Q7.0.
- `out_none` out 1: Σμ was zero, so no rule fired.
- `out_ovf` out 1: frame carried more than `N_RULES` beats.

## Operation
- States are IDLE, ACC, DIV and OUT. IDLE and ACC are the same from the port's point of view: `in_ready`=1 in both. `in_ready`=0 in DIV and OUT.
- Beat accepted on `in_valid`&&`in_ready`:
  - `in_mu` is clamped to 0x7FFF if bit15 is set.
  - sw += μ. Width is 15+$clog2(N_RULES+1) bits, unsigned.
  - swz += μ·z. Width is 23+$clog2(N_RULES+1) bits, signed.
  - The beat counter increments.
- Beats beyond `N_RULES` in one frame are accepted but not accumulated, and the sticky ovf flag is set.
- The `in_last` beat is accumulated like any other beat, then:
  - if sw==0, go to OUT with y=0 and none=1.
  - otherwise go to DIV.
- DIV uses restoring unsigned division of |swz| by sw.
  - It produces 8 quotient bits, one per cycle, MSB first.
  - The sign of swz is applied afterwards.
  - The result is saturated to [-128,127]. This can only trigger on +128, which is impossible by construction but is still clamped.
- Rounding behaviour depends on the configuration macro (see Configuration).
- OUT:
  - `out_valid`=1, and `out_y`, `out_none`, `out_ovf` are held stable until `out_ready`.
  - On the handshake, clear the accumulators, counter and flags, then go to IDLE.
- `in_valid` is ignored while `in_ready`=0. Inputs need not be stable outside a handshake.

## Timing
- Reset value of all outputs is 0, except `in_ready`=1. State is IDLE. Both accumulators and the counter are 0.
- One beat is accepted per cycle while in IDLE/ACC.
- Latency is measured from the cycle E at whose clock edge the `in_last` handshake occurs:
  - sw≠0: DIV occupies E+1..E+8, and `out_valid` rises at E+9.
  - sw=0: `out_valid` rises at E+1.
- `in_ready` falls at E+1 and rises in the cycle after the output handshake.
- A single-beat frame (`in_last` on the first beat) is legal.
- When `out_ready` is already 1 as `out_valid` rises, the result is consumed in one cycle.
- Reset asserted in any state, including mid-DIV or mid-OUT, aborts the frame immediately. No result is emitted.

## Configuration
- Macro `FUZZY_DEFUZZ_ROUND_EN`:
  - Defined: round half away from zero. Add floor(sw/2) to |swz| before dividing.
  - Undefined: truncate toward zero.
- Latency is identical in both builds.

## Structure
- Shared package `fuzzy_pkg` holds:
  - `mu_t` (16-bit Q1.15) and `q7_t` (signed 8-bit).
  - `MU_ONE` = 16'h7FFF.
  - the `defuzz_state_e` enum.
- The trapezoid stage and the rule logic import the same `mu_t`/`MU_ONE`.
- Sub-module `serial_udiv`:
  - Parameterised dividend/divisor width and quotient bits (8).
  - Interface: start/busy/done, holding the quotient until the next start.
  - `fuzzy_defuzz` instantiates it in DIV.

## Test plan
- Two beats (0x7FFF, 40) then (0x7FFF, -20, last): `out_y`=10, `out_none`=0, `out_valid` at E+9.
- Single beat (0x4000, -100, last): `out_y`=-100. A second frame immediately after the handshake gives an independent result with no leakage.
- Three beats, all μ=0: `out_y`=0, `out_none`=1, `out_valid` at E+1.
- Beats (0x7FFF, 1), (0x7FFF, 2): truncate build gives 1, round build gives 2. The same beats with z=-1/-2 give -1 or -2 respectively.
- Hold `out_ready`=0 for 5 cycles in OUT: outputs stay stable, `in_ready`=0, and driven `in_valid` beats are not accumulated.
- N_RULES+2 beats of (0x7FFF, 50): `out_y`=50 and `out_ovf`=1. Separately, assert `rst` at E+4: all outputs are reset values, and the next frame is correct.

Source files
------------

// File: rtl/fuzzy_defuzz_pkg.sv
// Shared fuzzy-datapath types: Q1.15 strength, Q7.0 crisp value, defuzzifier states.
// Imported by the trapezoid stage, rule logic and defuzzifier.
package fuzzy_pkg;
  typedef logic [15:0]        mu_t;
  typedef logic signed [7:0]  q7_t;

  localparam mu_t MU_ONE = 16'h7FFF;

  typedef enum logic [1:0] {IDLE, ACC, DIV, OUT} defuzz_state_e;
endpackage

// File: rtl/fuzzy_defuzz_if.sv
// Rule-beat input stream and crisp-result output stream of the defuzzifier.
interface fuzzy_defuzz_if
  import fuzzy_pkg::*;
();
  logic in_valid;
  logic in_ready;
  mu_t  in_mu;
  q7_t  in_z;
  logic in_last;
  logic out_valid;
  logic out_ready;
  q7_t  out_y;
  logic out_none;
  logic out_ovf;

  modport master (
    output in_valid, in_mu, in_z, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_none, out_ovf
  );

  modport slave (
    input  in_valid, in_mu, in_z, in_last, out_ready,
    output in_ready, out_valid, out_y, out_none, out_ovf
  );
endinterface

// File: rtl/fuzzy_defuzz_serial_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first; the first bit
// is resolved on the start edge, done marks the edge that latches the last bit.
module serial_udiv #(
  parameter int unsigned DVD_W  = 28,
  parameter int unsigned DVS_W  = 19,
  parameter int unsigned Q_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DVD_W-1:0]  dividend,
  input  logic [DVS_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [Q_BITS-1:0] quotient
);
  localparam int unsigned CNT_W = $clog2(Q_BITS + 1);

  logic [DVS_W-1:0]  rem_q, dvs_q, rem_cur, dvs_cur, rem_next;
  logic [Q_BITS-1:0] low_q, low_cur;
  logic [CNT_W-1:0]  cnt_q, cnt_cur;
  logic [DVS_W:0]    trial;
  logic              take;

  // Quotient fits in Q_BITS, so the dividend bits above them are already below the divisor.
  always_comb begin
    rem_cur  = start ? DVS_W'(dividend >> Q_BITS) : rem_q;
    low_cur  = start ? dividend[Q_BITS-1:0] : low_q;
    dvs_cur  = start ? divisor : dvs_q;
    cnt_cur  = start ? '0 : cnt_q;
    trial    = {rem_cur, low_cur[Q_BITS-1]};
    take     = (trial >= {1'b0, dvs_cur});
    rem_next = take ? DVS_W'(trial - {1'b0, dvs_cur}) : DVS_W'(trial);
    done     = (start || busy) && (cnt_cur == CNT_W'(Q_BITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      low_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start || busy) begin
      rem_q    <= rem_next;
      dvs_q    <= dvs_cur;
      low_q    <= low_cur << 1;
      cnt_q    <= cnt_cur + CNT_W'(1);
      busy     <= !done;
      quotient <= {quotient[Q_BITS-2:0], take};
    end
  end
endmodule

// File: rtl/fuzzy_defuzz.sv
// Sequential singleton-centroid defuzzifier: y = sum(mu*z) / sum(mu), serial divide.
// Define FUZZY_DEFUZZ_ROUND_EN for round-half-away-from-zero, else truncation.
module fuzzy_defuzz
  import fuzzy_pkg::*;
#(
  parameter int unsigned N_RULES = 9
) (
  input logic           clk,
  input logic           rst,
  fuzzy_defuzz_if.slave bus
);
  localparam int unsigned CW    = $clog2(N_RULES + 1);
  localparam int unsigned SW_W  = 15 + CW;
  localparam int unsigned SWZ_W = 23 + CW;
  localparam int unsigned DVD_W = SWZ_W + 1;
  localparam logic signed [8:0] Y_MAX = 9'sd127;
  localparam logic signed [8:0] Y_MIN = -9'sd128;

  defuzz_state_e           state, state_next;
  logic [SW_W-1:0]         sw, sw_next;
  logic signed [SWZ_W-1:0] swz, swz_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    ovf, ovf_next, none, none_next;
  logic [14:0]             mu_c;
  logic signed [SWZ_W-1:0] mu_ext, z_ext;
  logic                    in_rdy, beat, in_room;
  logic [SWZ_W-1:0]        swz_mag;
  logic [DVD_W-1:0]        dividend;
  logic                    div_start, div_busy, div_done;
  logic [7:0]              quo;
  logic signed [8:0]       y_wide;
  q7_t                     y_sat;

  always_comb begin
    in_rdy  = (state == IDLE) || (state == ACC);
    beat    = bus.in_valid && in_rdy;
    in_room = (cnt < CW'(N_RULES));
    mu_c    = bus.in_mu[15] ? MU_ONE[14:0] : bus.in_mu[14:0];
    mu_ext  = SWZ_W'({1'b0, mu_c});
    z_ext   = SWZ_W'(bus.in_z);
  end

  always_comb begin
    state_next = state;
    sw_next    = sw;
    swz_next   = swz;
    cnt_next   = cnt;
    ovf_next   = ovf;
    none_next  = none;
    div_start  = 1'b0;
    case (state)
      IDLE, ACC: begin
        if (beat) begin
          if (in_room) begin
            sw_next  = sw + SW_W'(mu_c);
            swz_next = swz + mu_ext * z_ext;
            cnt_next = cnt + CW'(1);
          end else begin
            ovf_next = 1'b1;
          end
          if (bus.in_last) begin
            if (sw_next == '0) begin
              state_next = OUT;
              none_next  = 1'b1;
            end else begin
              state_next = DIV;
            end
          end else begin
            state_next = ACC;
          end
        end
      end
      DIV: begin
        div_start = !div_busy;
        if (div_done) state_next = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          sw_next    = '0;
          swz_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          none_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sw    <= '0;
      swz   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      none  <= 1'b0;
    end else begin
      state <= state_next;
      sw    <= sw_next;
      swz   <= swz_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
      none  <= none_next;
    end
  end

  always_comb begin
    swz_mag = swz[SWZ_W-1] ? SWZ_W'(-swz) : SWZ_W'(swz);
`ifdef FUZZY_DEFUZZ_ROUND_EN
    dividend = {1'b0, swz_mag} + DVD_W'(sw >> 1);
`else
    dividend = {1'b0, swz_mag};
`endif
  end

  serial_udiv #(
    .DVD_W (DVD_W),
    .DVS_W (SW_W),
    .Q_BITS(8)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(dividend),
    .divisor (sw),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(quo)
  );

  always_comb begin
    y_wide = swz[SWZ_W-1] ? -$signed({1'b0, quo}) : $signed({1'b0, quo});
    if (y_wide > Y_MAX)      y_sat = q7_t'(Y_MAX);
    else if (y_wide < Y_MIN) y_sat = q7_t'(Y_MIN);
    else                     y_sat = q7_t'(y_wide);
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == OUT);
  assign bus.out_y     = ((state == OUT) && !none) ? y_sat : '0;
  assign bus.out_none  = (state == OUT) && none;
  assign bus.out_ovf   = (state == OUT) && ovf;
endmodule

// File: tb/tb_fuzzy_defuzz.sv
// Self-checking bench for fuzzy_defuzz: directed frames plus random frames vs a centroid model.
module tb_fuzzy_defuzz;
  import fuzzy_pkg::*;

  localparam int unsigned NR = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fuzzy_defuzz_if bus();

  fuzzy_defuzz #(.N_RULES(NR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int fr_mu[$];
  int fr_z[$];
  logic signed [31:0] obs_y, obs_none, obs_ovf;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(output int y, output int none, output int ovf);
    longint sw, swz, a, q;
    sw = 0;
    swz = 0;
    for (int i = 0; i < fr_mu.size(); i++) begin
      if (i < NR) begin
        longint m;
        m = (fr_mu[i] > 32767) ? 32767 : fr_mu[i];
        sw  += m;
        swz += m * fr_z[i];
      end
    end
    ovf  = (fr_mu.size() > NR) ? 1 : 0;
    none = (sw == 0) ? 1 : 0;
    if (sw == 0) begin
      y = 0;
    end else begin
      a = (swz < 0) ? -swz : swz;
`ifdef FUZZY_DEFUZZ_ROUND_EN
      q = (a + sw / 2) / sw;
`else
      q = a / sw;
`endif
      if (swz < 0) q = -q;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      y = int'(q);
    end
  endtask

  task automatic add_beat(input int mu, input int z);
    fr_mu.push_back(mu);
    fr_z.push_back(z);
  endtask

  task automatic clear_frame();
    fr_mu.delete();
    fr_z.delete();
  endtask

  // Called at a negedge; returns at the negedge of cycle E+1.
  task automatic send_beats(input string tag);
    for (int i = 0; i < fr_mu.size(); i++) begin
      int w;
      bus.in_valid = 1'b1;
      bus.in_mu    = mu_t'(fr_mu[i]);
      bus.in_z     = q7_t'(fr_z[i]);
      bus.in_last  = (i == fr_mu.size() - 1);
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      check({tag, "/beat_in_ready"}, bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_mu    = mu_t'($urandom);
    bus.in_z     = q7_t'($urandom);
  endtask

  task automatic run_frame(input string tag, input int hold, input bit ready_early);
    int ey, en, eo, k;
    model(ey, en, eo);
    bus.out_ready = ready_early;
    send_beats(tag);
    check({tag, "/in_ready_low"}, bus.in_ready, 0);
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/latency"}, k, (en != 0) ? 1 : 9);
    obs_y    = bus.out_y;
    obs_none = bus.out_none;
    obs_ovf  = bus.out_ovf;
    check({tag, "/y"}, obs_y, ey);
    check({tag, "/none"}, obs_none, en);
    check({tag, "/ovf"}, obs_ovf, eo);
    if (!ready_early) begin
      for (int c = 0; c < hold; c++) begin
        bus.in_valid = 1'b1;
        bus.in_mu    = mu_t'($urandom);
        bus.in_z     = q7_t'($urandom);
        bus.in_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, "/hold_valid"}, bus.out_valid, 1);
        check({tag, "/hold_in_ready"}, bus.in_ready, 0);
        check({tag, "/hold_y"}, bus.out_y, ey);
        check({tag, "/hold_none"}, bus.out_none, en);
        check({tag, "/hold_ovf"}, bus.out_ovf, eo);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "/valid_drop"}, bus.out_valid, 0);
    check({tag, "/in_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/rst_in_ready"}, bus.in_ready, 1);
    check({tag, "/rst_out_valid"}, bus.out_valid, 0);
    check({tag, "/rst_out_y"}, bus.out_y, 0);
    check({tag, "/rst_out_none"}, bus.out_none, 0);
    check({tag, "/rst_out_ovf"}, bus.out_ovf, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mu     = '0;
    bus.in_z      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    clear_frame();
    add_beat(32'h7FFF, 40);
    add_beat(32'h7FFF, -20);
    run_frame("two_beat", 2, 1'b0);
    check("two_beat/y_const", obs_y, 10);

    clear_frame();
    add_beat(32'h4000, -100);
    run_frame("single", 0, 1'b1);
    check("single/y_const", obs_y, -100);
    clear_frame();
    add_beat(32'h7FFF, 30);
    add_beat(32'h2000, -90);
    run_frame("after_single", 1, 1'b0);

    clear_frame();
    for (int i = 0; i < 3; i++) add_beat(0, 17 * i - 60);
    run_frame("zero_mu", 1, 1'b0);
    check("zero_mu/none_const", obs_none, 1);
    check("zero_mu/y_const", obs_y, 0);

    clear_frame();
    add_beat(32'h7FFF, 1);
    add_beat(32'h7FFF, 2);
    run_frame("round_pos", 0, 1'b0);
`ifdef FUZZY_DEFUZZ_ROUND_EN
    check("round_pos/y_const", obs_y, 2);
`else
    check("round_pos/y_const", obs_y, 1);
`endif
    clear_frame();
    add_beat(32'h7FFF, -1);
    add_beat(32'h7FFF, -2);
    run_frame("round_neg", 0, 1'b0);
`ifdef FUZZY_DEFUZZ_ROUND_EN
    check("round_neg/y_const", obs_y, -2);
`else
    check("round_neg/y_const", obs_y, -1);
`endif

    clear_frame();
    add_beat(32'h6000, 77);
    add_beat(32'h1234, -5);
    add_beat(32'hC000, 12);
    run_frame("hold5", 5, 1'b0);

    clear_frame();
    for (int i = 0; i < NR + 2; i++) add_beat(32'h7FFF, 50);
    run_frame("overflow", 1, 1'b0);
    check("overflow/y_const", obs_y, 50);
    check("overflow/ovf_const", obs_ovf, 1);

    clear_frame();
    for (int i = 0; i < 3; i++) add_beat(32'h7FFF, 60);
    send_beats("abort");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_frame();
    add_beat(32'h7FFF, -7);
    run_frame("after_abort", 0, 1'b0);
    check("after_abort/y_const", obs_y, -7);

    for (int f = 0; f < 25; f++) begin
      int len;
      clear_frame();
      len = $urandom_range(1, NR + 3);
      for (int i = 0; i < len; i++) begin
        int sel, mu;
        sel = $urandom_range(0, 3);
        if (sel == 0)      mu = 0;
        else if (sel == 1) mu = $urandom_range(32768, 65535);
        else               mu = $urandom_range(0, 32767);
        add_beat(mu, $urandom_range(0, 255) - 128);
      end
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
